vga_timing_gen: RTL and testbench

- Downstream stage of the AXI4-Lite VGA register block.
- Consumes the register-block control/colour fields and generates VGA raster timing (hsync, vsync, data-enable) plus a 12-bit RGB test pattern.
- Runs on the AXI clock with an internal pixel-enable divider.
- Register values are shadowed at frame boundaries so software writes never tear a frame.

---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/vga_pattern_gen.sv | 34 +++
 rtl/vga_timing_gen.sv | 214 +++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 timing for the VGA raster generator.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    PAT_SOLID   = 2'd0,
    PAT_CHECKER = 2'd1,
    PAT_BARS    = 2'd2,
    PAT_BORDER  = 2'd3
  } pattern_e;

  typedef logic [11:0] rgb12_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_SYNC_POL = 0;
  localparam int DEF_PIX_DIV  = 4;

  // Bar 0 is white, bar 7 is black; each bit of the index blanks one channel.
  function automatic rgb12_t bar_color(input logic [2:0] b);
    return {{4{~b[2]}}, {4{~b[1]}}, {4{~b[0]}}};
  endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// Combinational test-pattern colour for one active pixel.
module vga_pattern_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE
) (
  input  logic [15:0] x_i,
  input  logic [15:0] y_i,
  input  logic [2:0]  bar_idx_i,
  input  pattern_e    pattern_i,
  input  rgb12_t      fg_i,
  input  rgb12_t      bg_i,
  output rgb12_t      rgb_o
);

  localparam logic [15:0] X_LAST = 16'(H_ACTIVE - 1);
  localparam logic [15:0] Y_LAST = 16'(V_ACTIVE - 1);

  logic on_border;

  always_comb begin
    on_border = (x_i == 16'd0) || (x_i == X_LAST) || (y_i == 16'd0) || (y_i == Y_LAST);
    rgb_o     = fg_i;
    case (pattern_i)
      PAT_SOLID:   rgb_o = fg_i;
      PAT_CHECKER: rgb_o = (x_i[5] ^ y_i[5]) ? bg_i : fg_i;
      PAT_BARS:    rgb_o = bar_color(bar_idx_i);
      PAT_BORDER:  rgb_o = on_border ? fg_i : bg_i;
      default:     rgb_o = fg_i;
    endcase
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing with pixel-enable divider, frame-boundary shadowing of
// the control/colour fields and registered sync/DE/RGB outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SYNC_POL = DEF_SYNC_POL,
  parameter int PIX_DIV  = DEF_PIX_DIV
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        ctrl_enable,
  input  logic [1:0]  ctrl_pattern,
  input  logic [11:0] fg_color,
  input  logic [11:0] bg_color,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] rgb,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic          SYNC_ON  = 1'(SYNC_POL);
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  // One extra bit so sync-end compares cannot overflow when a back porch is zero.
  localparam logic [HW:0]   H_ACT_L  = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0]   HS_BEG_L = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0]   HS_END_L = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW:0]   V_ACT_L  = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0]   VS_BEG_L = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic [VW:0]   VS_END_L = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic          enable_q;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [BW-1:0] bar_px_q, bar_px_d;
  logic [2:0]    bar_idx_q, bar_idx_d;
  pattern_e      pat_q, pat_d;
  rgb12_t        fg_q, fg_d, bg_q, bg_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, fs_q, fs_d;
  rgb12_t        rgb_q, rgb_d;
  logic [9:0]    px_q, px_d, py_q, py_d;

  logic          pix_en, h_last, v_last, de_c, hs_c, vs_c;
  logic [HW:0]   h_ext;
  logic [VW:0]   v_ext;
  rgb12_t        pat_rgb;

  always_comb begin
    pix_en = enable_q && (div_cnt_q == DIV_LAST);
    h_last = (h_cnt_q == H_LAST);
    v_last = (v_cnt_q == V_LAST);
    h_ext  = {1'b0, h_cnt_q};
    v_ext  = {1'b0, v_cnt_q};
    de_c   = (h_ext < H_ACT_L) && (v_ext < V_ACT_L);
    hs_c   = (h_ext >= HS_BEG_L) && (h_ext < HS_END_L);
    vs_c   = (v_ext >= VS_BEG_L) && (v_ext < VS_END_L);
  end

  vga_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_pattern (
    .x_i       (16'(h_cnt_q)),
    .y_i       (16'(v_cnt_q)),
    .bar_idx_i (bar_idx_q),
    .pattern_i (pat_q),
    .fg_i      (fg_q),
    .bg_i      (bg_q),
    .rgb_o     (pat_rgb)
  );

  // Raster counters; the bar counter tracks h_cnt so bars need no divider.
  always_comb begin
    div_cnt_d = div_cnt_q;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    bar_px_d  = bar_px_q;
    bar_idx_d = bar_idx_q;
    if (!enable_q) begin
      div_cnt_d = '0;
      h_cnt_d   = '0;
      v_cnt_d   = '0;
      bar_px_d  = '0;
      bar_idx_d = '0;
    end else begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
      if (pix_en) begin
        if (h_last) begin
          h_cnt_d   = '0;
          bar_px_d  = '0;
          bar_idx_d = '0;
          v_cnt_d   = v_last ? '0 : v_cnt_q + 1'b1;
        end else begin
          h_cnt_d = h_cnt_q + 1'b1;
          if (bar_px_q == BAR_LAST) begin
            bar_px_d  = '0;
            bar_idx_d = bar_idx_q + 1'b1;
          end else begin
            bar_px_d = bar_px_q + 1'b1;
          end
        end
      end
    end
  end

  // Shadows follow the inputs while idle, otherwise only on the last pixel of a frame.
  always_comb begin
    pat_d = pat_q;
    fg_d  = fg_q;
    bg_d  = bg_q;
    if (!enable_q || (pix_en && h_last && v_last)) begin
      pat_d = pattern_e'(ctrl_pattern);
      fg_d  = fg_color;
      bg_d  = bg_color;
    end
  end

  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    de_d    = de_q;
    rgb_d   = rgb_q;
    px_d    = px_q;
    py_d    = py_q;
    fs_d    = 1'b0;
    if (!enable_q) begin
      hsync_d = ~SYNC_ON;
      vsync_d = ~SYNC_ON;
      de_d    = 1'b0;
      rgb_d   = '0;
      px_d    = '0;
      py_d    = '0;
    end else if (pix_en) begin
      hsync_d = hs_c ? SYNC_ON : ~SYNC_ON;
      vsync_d = vs_c ? SYNC_ON : ~SYNC_ON;
      de_d    = de_c;
      rgb_d   = de_c ? pat_rgb : '0;
      fs_d    = (h_cnt_q == '0) && (v_cnt_q == '0);
      if (de_c) begin
        px_d = 10'(h_cnt_q);
        py_d = 10'(v_cnt_q);
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      enable_q  <= 1'b0;
      div_cnt_q <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      bar_px_q  <= '0;
      bar_idx_q <= '0;
      pat_q     <= PAT_SOLID;
      fg_q      <= '0;
      bg_q      <= '0;
      hsync_q   <= ~SYNC_ON;
      vsync_q   <= ~SYNC_ON;
      de_q      <= 1'b0;
      rgb_q     <= '0;
      px_q      <= '0;
      py_q      <= '0;
      fs_q      <= 1'b0;
    end else begin
      enable_q  <= ctrl_enable;
      div_cnt_q <= div_cnt_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      bar_px_q  <= bar_px_d;
      bar_idx_q <= bar_idx_d;
      pat_q     <= pat_d;
      fg_q      <= fg_d;
      bg_q      <= bg_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      de_q      <= de_d;
      rgb_q     <= rgb_d;
      px_q      <= px_d;
      py_q      <= py_d;
      fs_q      <= fs_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign rgb         = rgb_q;
  assign pixel_x     = px_q;
  assign pixel_y     = py_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a tiny-timing instance (PIX_DIV=1) for raster shape and a
// full-width instance (PIX_DIV=2, short frame) for bars, shadowing and enable.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_en, b_en;
  logic [1:0]  a_pat, b_pat;
  logic [11:0] a_fg, a_bg, b_fg, b_bg;
  logic        a_hs, a_vs, a_de, a_fs, b_hs, b_vs, b_de, b_fs;
  logic [11:0] a_rgb, b_rgb;
  logic [9:0]  a_px, a_py, b_px, b_py;

  int total = 0;
  int bad   = 0;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(0), .PIX_DIV(1)
  ) dut_a (
    .ACLK(clk), .ARESETN(rst_n), .ctrl_enable(a_en), .ctrl_pattern(a_pat),
    .fg_color(a_fg), .bg_color(a_bg), .hsync(a_hs), .vsync(a_vs), .de(a_de),
    .rgb(a_rgb), .pixel_x(a_px), .pixel_y(a_py), .frame_start(a_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(0), .PIX_DIV(2)
  ) dut_b (
    .ACLK(clk), .ARESETN(rst_n), .ctrl_enable(b_en), .ctrl_pattern(b_pat),
    .fg_color(b_fg), .bg_color(b_bg), .hsync(b_hs), .vsync(b_vs), .de(b_de),
    .rgb(b_rgb), .pixel_x(b_px), .pixel_y(b_py), .frame_start(b_fs)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[%0t] FAIL %s: got %0h expected %0h", $time, tag, got, exp);
    end else begin
      $display("[%0t] ok   %s: %0h", $time, tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_b(input int x, input int y, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 30000 && !found; i++) begin
      tick();
      if (b_de && b_px == 10'(x) && b_py == 10'(y)) found = 1'b1;
    end
    chk({tag, "_reach"}, 32'(found), 32'd1);
  endtask

  task automatic wait_fs(input logic use_b, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 30000 && !found; i++) begin
      tick();
      if (use_b ? b_fs : a_fs) found = 1'b1;
    end
    chk({tag, "_reach"}, 32'(found), 32'd1);
  endtask

  int hs_low[7];
  int de_hi[7];
  int vs_low, fs_cnt, solid_bad, f00_cnt, lat_a, lat_b, lat_r;
  logic [9:0] px7, py3;
  logic hs10;

  initial begin
    rst_n = 1'b0;
    a_en = 1'b1; a_pat = 2'd0; a_fg = 12'hF00; a_bg = 12'h00A;
    b_en = 1'b1; b_pat = 2'd2; b_fg = 12'h123; b_bg = 12'h456;
    repeat (3) tick();

    chk("rst_a_hs",  32'(a_hs),  32'd1);
    chk("rst_a_vs",  32'(a_vs),  32'd1);
    chk("rst_a_de",  32'(a_de),  32'd0);
    chk("rst_a_rgb", 32'(a_rgb), 32'h000);
    chk("rst_a_fs",  32'(a_fs),  32'd0);
    chk("rst_a_px",  32'(a_px),  32'd0);
    chk("rst_b_hs",  32'(b_hs),  32'd1);
    chk("rst_b_vs",  32'(b_vs),  32'd1);
    chk("rst_b_de",  32'(b_de),  32'd0);
    chk("rst_b_rgb", 32'(b_rgb), 32'h000);

    @(negedge clk);
    rst_n = 1'b1;
    lat_a = 0; lat_b = 0;
    for (int n = 1; n <= 20 && (lat_a == 0 || lat_b == 0); n++) begin
      tick();
      if (a_fs && lat_a == 0) lat_a = n;
      if (b_fs && lat_b == 0) lat_b = n;
    end
    chk("a_fs_latency", 32'(lat_a), 32'd2);
    chk("b_fs_latency", 32'(lat_b), 32'd3);

    // One full 98-cycle frame of the tiny raster, starting at its frame_start.
    wait_fs(1'b0, "a_fs2");
    vs_low = 0; fs_cnt = 0; solid_bad = 0; f00_cnt = 0;
    for (int l = 0; l < 7; l++) begin
      hs_low[l] = 0;
      de_hi[l]  = 0;
    end
    for (int i = 0; i < 98; i++) begin
      if (i > 0) tick();
      if (!a_hs) hs_low[i/14]++;
      if (a_de)  de_hi[i/14]++;
      if (!a_vs) vs_low++;
      if (a_fs)  fs_cnt++;
      if (a_rgb == 12'hF00) f00_cnt++;
      if (a_rgb !== (a_de ? 12'hF00 : 12'h000)) solid_bad++;
      if (i == 7)  px7 = a_px;
      if (i == 44) py3 = a_py;
      if (i == 10) hs10 = a_hs;
    end
    for (int l = 0; l < 7; l++) begin
      chk($sformatf("a_hs_low_line%0d", l), 32'(hs_low[l]), 32'd2);
      chk($sformatf("a_de_line%0d", l), 32'(de_hi[l]), (l < 4) ? 32'd8 : 32'd0);
    end
    chk("a_vs_low",     32'(vs_low),    32'd14);
    chk("a_fs_count",   32'(fs_cnt),    32'd1);
    chk("a_solid_bad",  32'(solid_bad), 32'd0);
    chk("a_solid_cnt",  32'(f00_cnt),   32'd32);
    chk("a_px_at7",     32'(px7),       32'd7);
    chk("a_py_line3",   32'(py3),       32'd3);
    chk("a_hs_at10",    32'(hs10),      32'd0);
    tick();
    chk("a_fs_period",  32'(a_fs),      32'd1);

    // Colour bars on line 1 of the full-width raster.
    wait_b(0, 1, "bar_x0");     chk("bar_x0_rgb",   32'(b_rgb), 32'hFFF);
    wait_b(79, 1, "bar_x79");   chk("bar_x79_rgb",  32'(b_rgb), 32'hFFF);
    wait_b(80, 1, "bar_x80");   chk("bar_x80_rgb",  32'(b_rgb), 32'hFF0);
    wait_b(160, 1, "bar_x160"); chk("bar_x160_rgb", 32'(b_rgb), 32'hF0F);
    wait_b(560, 1, "bar_x560"); chk("bar_x560_rgb", 32'(b_rgb), 32'h000);
    wait_b(639, 1, "bar_x639"); chk("bar_x639_rgb", 32'(b_rgb), 32'h000);
    repeat (4) tick();
    chk("blank_de",   32'(b_de),  32'd0);
    chk("blank_rgb",  32'(b_rgb), 32'h000);
    chk("blank_px_hold", 32'(b_px), 32'd639);

    // Shadowing: mid-frame writes only show from the next frame.
    b_pat = 2'd0;
    b_fg  = 12'h0F0;
    wait_fs(1'b1, "shadow_fs1");
    chk("shadow_f1_rgb", 32'(b_rgb), 32'h0F0);
    chk("shadow_f1_px",  32'(b_px),  32'd0);
    wait_b(0, 2, "shadow_l2");
    b_fg = 12'h00F;
    wait_b(5, 3, "shadow_l3");
    chk("shadow_hold_rgb", 32'(b_rgb), 32'h0F0);
    wait_fs(1'b1, "shadow_fs2");
    chk("shadow_new_rgb", 32'(b_rgb), 32'h00F);

    // Enable drop mid-frame, then restart with the checkerboard.
    wait_b(100, 2, "drop_at");
    b_pat = 2'd1;
    b_bg  = 12'hA5A;
    b_en  = 1'b0;
    tick();
    tick();
    chk("drop_de",  32'(b_de),  32'd0);
    chk("drop_rgb", 32'(b_rgb), 32'h000);
    chk("drop_hs",  32'(b_hs),  32'd1);
    chk("drop_vs",  32'(b_vs),  32'd1);
    chk("drop_px",  32'(b_px),  32'd0);
    chk("drop_py",  32'(b_py),  32'd0);
    repeat (5) tick();
    chk("drop_fs_idle", 32'(b_fs), 32'd0);
    b_en = 1'b1;
    lat_r = 0;
    for (int n = 1; n <= 20 && lat_r == 0; n++) begin
      tick();
      if (b_fs) lat_r = n;
    end
    chk("restart_fs_latency", 32'(lat_r), 32'd3);
    chk("restart_rgb_00",     32'(b_rgb), 32'h00F);
    wait_b(32, 0, "chk_x32");
    chk("chk_x32_rgb", 32'(b_rgb), 32'hA5A);
    wait_b(64, 0, "chk_x64");
    chk("chk_x64_rgb", 32'(b_rgb), 32'h00F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
